// File: rtl/ps_axi_fifo_pkg.sv
// Register offsets, response codes and FSM state types shared by the PS AXI FIFO responder.
// Pure definitions: no logic, no latency, no backpressure.
package ps_axi_fifo_pkg;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {SEL_DATA, SEL_STATUS, SEL_CTRL, SEL_BAD} reg_sel_e;

  function automatic reg_sel_e decode_reg(input logic [3:0] offs);
    case (offs)
      REG_DATA:   return SEL_DATA;
      REG_STATUS: return SEL_STATUS;
      REG_CTRL:   return SEL_CTRL;
      default:    return SEL_BAD;
    endcase
  endfunction

endpackage

// File: rtl/axi_word_fifo.sv
// Synchronous word FIFO with flush; head is combinational, push/pop/flush land on the next edge.
// Push while full and pop while empty are ignored; flush overrides both in the same cycle.
module axi_word_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/ps_axi_fifo_slave.sv
// AXI4 responder turning PS bursts into TX/RX word streams plus STATUS/CTRL registers; B and R start one cycle after wlast/AR.
// W stalls only on DATA writes while TX is full; R never stalls (empty RX reads return 0/SLVERR).
module ps_axi_fifo_slave
  import ps_axi_fifo_pkg::*;
#(
  parameter int ID_W       = 12,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_bits,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_bits
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  w_state_e    w_state;
  reg_sel_e    w_sel;
  logic        w_size_bad;
  logic        w_err;
  r_state_e    r_state;
  reg_sel_e    r_sel;
  logic [7:0]  r_cnt;
  logic        run_q;

  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [DATA_W-1:0] rx_head;
  logic [31:0]   status_word;
  logic          w_hs, beat_good, tx_push, flush, rx_pop;
  logic          unused_bits;

  assign unused_bits = ^{s_axi_awaddr[ADDR_W-1:4], s_axi_araddr[ADDR_W-1:4], s_axi_awlen,
                         s_axi_awburst, s_axi_arsize, s_axi_arburst};

  // wready looks only at the registered full flag, so a same-cycle pop cannot unblock a push.
  assign s_axi_wready = (w_state == W_DATA) && !((w_sel == SEL_DATA) && tx_full);
  assign w_hs         = s_axi_wvalid && s_axi_wready;
  assign beat_good    = !w_size_bad && (s_axi_wstrb == 4'hF) && (w_sel != SEL_BAD);
  assign tx_push      = w_hs && beat_good && (w_sel == SEL_DATA);
  assign flush        = w_hs && beat_good && (w_sel == SEL_CTRL) && s_axi_wdata[0];

  assign out_valid   = !tx_empty;
  assign in_ready    = run_q && !rx_full;
  assign s_axi_rlast = s_axi_rvalid && (r_cnt == 8'd0);
  assign rx_pop      = s_axi_rvalid && s_axi_rready && (r_sel == SEL_DATA) && !rx_empty;
  assign status_word = {16'(rx_count), 16'(FIFO_DEPTH) - 16'(tx_count)};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_state       <= W_IDLE;
      w_sel         <= SEL_DATA;
      w_size_bad    <= 1'b0;
      w_err         <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            s_axi_awready <= 1'b0;
            s_axi_bid     <= s_axi_awid;
            w_sel         <= decode_reg(s_axi_awaddr[3:0]);
            w_size_bad    <= (s_axi_awsize != 3'd2);
            w_err         <= 1'b0;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (!beat_good) w_err <= 1'b1;
            if (s_axi_wlast) begin
              s_axi_bresp  <= (w_err || !beat_good) ? RESP_SLVERR : RESP_OKAY;
              s_axi_bvalid <= 1'b1;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= R_IDLE;
      r_sel         <= SEL_DATA;
      r_cnt         <= 8'd0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rid     <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0;
            s_axi_rid     <= s_axi_arid;
            r_sel         <= decode_reg(s_axi_araddr[3:0]);
            r_cnt         <= s_axi_arlen;
            s_axi_rvalid  <= 1'b1;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (r_cnt == 8'd0) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    s_axi_rdata = '0;
    s_axi_rresp = RESP_OKAY;
    if (s_axi_rvalid) begin
      case (r_sel)
        SEL_DATA: begin
          if (rx_empty) s_axi_rresp = RESP_SLVERR;
          else          s_axi_rdata = rx_head;
        end
        SEL_STATUS: s_axi_rdata = status_word;
        SEL_BAD:    s_axi_rresp = RESP_SLVERR;
        default:    s_axi_rdata = '0;
      endcase
    end
  end

  axi_word_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_tx_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (tx_push),
    .push_dat (s_axi_wdata),
    .pop      (out_valid && out_ready),
    .flush    (flush),
    .head     (out_bits),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count)
  );

  axi_word_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_rx_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (in_valid && in_ready),
    .push_dat (in_bits),
    .pop      (rx_pop),
    .flush    (flush),
    .head     (rx_head),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (rx_count)
  );

endmodule

// File: tb/tb_ps_axi_fifo_slave.sv
// Directed bench for ps_axi_fifo_slave: AXI bursts against hand-computed stream, status and response values.
// Inputs change 1ns after the rising edge; streams are captured on the falling edge.
module tb_ps_axi_fifo_slave;
  localparam int BUDGET = 60;

  logic        clock;
  logic        reset_n;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic [11:0] s_axi_awid;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_bvalid, s_axi_bready;
  logic [11:0] s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic [11:0] s_axi_arid;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [11:0] s_axi_rid;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        out_valid, out_ready;
  logic [31:0] out_bits;
  logic        in_valid, in_ready;
  logic [31:0] in_bits;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          stall_beat = -1;
  logic [31:0] txq[$];
  logic [31:0] rd_dat  [8];
  logic [1:0]  rd_resp [8];
  logic        rd_last [8];
  logic [1:0]  resp;

  ps_axi_fifo_slave dut (
    .clock(clock), .reset_n(reset_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bid(s_axi_bid),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) txq.push_back(out_bits);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input int n, input logic [3:0] strb,
                          input logic [31:0] base, input logic [11:0] id, input bit hold_b,
                          input bit push_last, output logic [1:0] b_resp);
    int t;
    s_axi_awvalid = 1'b1;
    s_axi_awaddr  = addr;
    s_axi_awid    = id;
    s_axi_awlen   = 8'(n - 1);
    s_axi_awsize  = 3'd2;
    s_axi_awburst = 2'd1;
    t = 0;
    while (!s_axi_awready && t < BUDGET) begin step(); t++; end
    check_eq("aw_ready", 32'(s_axi_awready), 32'd1);
    step();
    s_axi_awvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = base + 32'(i);
      s_axi_wstrb  = strb;
      s_axi_wlast  = (i == n - 1);
      if (push_last && i == n - 1) begin
        in_valid = 1'b1;
        in_bits  = 32'hDEAD_0001;
      end
      t = 0;
      while (!s_axi_wready && t < BUDGET) begin
        if (t == 4 && !out_ready) begin
          stall_beat = i;
          out_ready  = 1'b1;
        end
        step();
        t++;
      end
      check_eq("w_ready", 32'(s_axi_wready), 32'd1);
      step();
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    in_valid     = 1'b0;
    check_eq("bvalid_after_wlast", 32'(s_axi_bvalid), 32'd1);
    check_eq("bid", 32'(s_axi_bid), 32'(id));
    b_resp = s_axi_bresp;
    if (!hold_b) begin
      s_axi_bready = 1'b1;
      step();
      s_axi_bready = 1'b0;
      check_eq("bvalid_clear", 32'(s_axi_bvalid), 32'd0);
    end
  endtask

  task automatic start_read(input logic [31:0] addr, input int n, input logic [11:0] id);
    int t;
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = addr;
    s_axi_arid    = id;
    s_axi_arlen   = 8'(n - 1);
    s_axi_arsize  = 3'd2;
    s_axi_arburst = 2'd1;
    t = 0;
    while (!s_axi_arready && t < BUDGET) begin step(); t++; end
    check_eq("ar_ready", 32'(s_axi_arready), 32'd1);
    step();
    s_axi_arvalid = 1'b0;
    check_eq("rvalid_after_ar", 32'(s_axi_rvalid), 32'd1);
    check_eq("rid", 32'(s_axi_rid), 32'(id));
  endtask

  task automatic do_read(input logic [31:0] addr, input int n, input logic [11:0] id);
    start_read(addr, n, id);
    s_axi_rready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check_eq("rvalid_beat", 32'(s_axi_rvalid), 32'd1);
      rd_dat[i]  = s_axi_rdata;
      rd_resp[i] = s_axi_rresp;
      rd_last[i] = s_axi_rlast;
      step();
    end
    s_axi_rready = 1'b0;
    check_eq("rvalid_clear", 32'(s_axi_rvalid), 32'd0);
  endtask

  task automatic push_in(input logic [31:0] d);
    in_valid = 1'b1;
    in_bits  = d;
    check_eq("in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [31:0] exp);
    do_read(32'h4, 1, 12'h044);
    check_eq(tag, rd_dat[0], exp);
    check_eq({tag, "_resp"}, 32'(rd_resp[0]), 32'd0);
    check_eq({tag, "_last"}, 32'(rd_last[0]), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    {s_axi_awvalid, s_axi_wvalid, s_axi_bready, s_axi_arvalid, s_axi_rready} = '0;
    s_axi_awaddr = '0; s_axi_awid = '0; s_axi_awlen = '0; s_axi_awsize = 3'd2; s_axi_awburst = 2'd1;
    s_axi_wdata = '0; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b0;
    s_axi_araddr = '0; s_axi_arid = '0; s_axi_arlen = '0; s_axi_arsize = 3'd2; s_axi_arburst = 2'd1;
    out_ready = 1'b0; in_valid = 1'b0; in_bits = '0;
    #2 reset_n = 1'b0;
    repeat (3) step();
    check_eq("rst_ctl", 32'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
                              s_axi_rvalid, s_axi_rlast, out_valid, in_ready}), 32'd0);
    check_eq("rst_rdata", s_axi_rdata, 32'd0);
    check_eq("rst_ids", 32'({s_axi_bid, s_axi_rid, s_axi_bresp, s_axi_rresp}), 32'd0);
    #2 reset_n = 1'b1;
    repeat (2) step();

    check_status("status_after_reset", 32'h0000_0010);

    // INCR burst of 4 to DATA, drained straight out.
    out_ready = 1'b1;
    txq.delete();
    do_write(32'h0, 4, 4'hF, 32'd1, 12'h123, 1'b0, 1'b0, resp);
    check_eq("wr4_bresp", 32'(resp), 32'd0);
    repeat (4) step();
    check_eq("wr4_count", 32'(txq.size()), 32'd4);
    for (int i = 0; i < 4 && i < txq.size(); i++) check_eq("wr4_data", txq[i], 32'(i + 1));

    // 20-beat burst into a 16-deep FIFO with the consumer stalled.
    out_ready = 1'b0;
    txq.delete();
    stall_beat = -1;
    do_write(32'h0, 20, 4'hF, 32'h100, 12'hABC, 1'b0, 1'b0, resp);
    check_eq("wr20_stall_beat", 32'(stall_beat), 32'd16);
    check_eq("wr20_bresp", 32'(resp), 32'd0);
    repeat (24) step();
    check_eq("wr20_count", 32'(txq.size()), 32'd20);
    for (int i = 0; i < 20 && i < txq.size(); i++) check_eq("wr20_data", txq[i], 32'h100 + 32'(i));

    // Two RX words, four-beat read: data then underflow SLVERR beats.
    push_in(32'hA1);
    push_in(32'hA2);
    do_read(32'h0, 4, 12'h7E5);
    check_eq("rd_b0", rd_dat[0], 32'hA1);
    check_eq("rd_b1", rd_dat[1], 32'hA2);
    check_eq("rd_b2", rd_dat[2], 32'h0);
    check_eq("rd_b3", rd_dat[3], 32'h0);
    check_eq("rd_resp", 32'({rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}), 32'b00_00_10_10);
    check_eq("rd_last", 32'({rd_last[0], rd_last[1], rd_last[2], rd_last[3]}), 32'b0001);

    // Partial strobe, bad offset, and STATUS write.
    out_ready = 1'b0;
    do_write(32'h0, 1, 4'h3, 32'h55, 12'h001, 1'b0, 1'b0, resp);
    check_eq("strb_bresp", 32'(resp), 32'd2);
    do_write(32'hC, 1, 4'hF, 32'h66, 12'h002, 1'b0, 1'b0, resp);
    check_eq("badaddr_bresp", 32'(resp), 32'd2);
    do_write(32'h4, 1, 4'hF, 32'h1234, 12'h003, 1'b0, 1'b0, resp);
    check_eq("status_wr_bresp", 32'(resp), 32'd0);
    do_read(32'hC, 1, 12'h004);
    check_eq("badaddr_rdata", rd_dat[0], 32'd0);
    check_eq("badaddr_rresp", 32'(rd_resp[0]), 32'd2);
    do_read(32'h8, 1, 12'h005);
    check_eq("ctrl_rd", 32'({rd_dat[0][29:0], rd_resp[0]}), 32'd0);
    check_status("status_tx_untouched", 32'h0000_0010);

    // Five TX words and one RX word, then flush racing an RX push.
    do_write(32'h0, 5, 4'hF, 32'h200, 12'h010, 1'b0, 1'b0, resp);
    push_in(32'hB1);
    check_status("status_before_flush", 32'h0001_000B);
    do_write(32'h8, 1, 4'hF, 32'h1, 12'h011, 1'b0, 1'b1, resp);
    check_eq("flush_bresp", 32'(resp), 32'd0);
    check_status("status_after_flush", 32'h0000_0010);
    check_eq("flush_out_valid", 32'(out_valid), 32'd0);

    // Reset with B pending and a read burst in flight.
    do_write(32'h4, 1, 4'hF, 32'h0, 12'h020, 1'b1, 1'b0, resp);
    start_read(32'h4, 8, 12'h021);
    check_eq("mid_both_valid", 32'({s_axi_bvalid, s_axi_rvalid}), 32'b11);
    #1 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valids", 32'({s_axi_bvalid, s_axi_rvalid, s_axi_rlast}), 32'd0);
    repeat (2) step();
    #2 reset_n = 1'b1;
    repeat (2) step();
    check_status("status_after_mid_reset", 32'h0000_0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
